// File: rtl/alu_exec_unit.sv
// Handshaked multi-cycle ALU: operands captured on accept, result and flags registered in EXEC.
// Define ALU_EXEC_SHIFT_EN to add sll (code 100), executed one bit per cycle in the SHIFT state.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             busy
);

`ifdef ALU_EXEC_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2, SHIFT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
`ifdef ALU_EXEC_SHIFT_EN
    logic [4:0]       cnt;
    logic [WIDTH-1:0] shl;
`endif

    // Handshake: a transfer happens on any cycle where valid and ready are both high at the
    // rising edge; a producer holds its payload stable while valid is high and ready is low.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = EXEC;
            EXEC: begin
                next_state = DONE;
`ifdef ALU_EXEC_SHIFT_EN
                if ((op_q == 3'b100) && (b_q[4:0] != 5'd0)) next_state = SHIFT;
`endif
            end
`ifdef ALU_EXEC_SHIFT_EN
            SHIFT: if (cnt == 5'd1) next_state = DONE;
`endif
            DONE: if (out_ready) next_state = in_valid ? EXEC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sum_add = {1'b0, a_q} + {1'b0, b_q};
        sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_add[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_sub[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`ifdef ALU_EXEC_SHIFT_EN
            // EXEC only seeds the shifter; the SHIFT state does the actual work.
            3'b100: alu_res = a_q;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    assign shl = {Result[WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            Result   <= '0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            cnt      <= '0;
`endif
        end else begin
            state <= next_state;
            if (in_valid && in_ready) begin
                op_q <= ALUControl;
                a_q  <= SrcA;
                b_q  <= SrcB;
            end
            if (state == EXEC) begin
                Result   <= alu_res;
                Zero     <= (alu_res == '0);
                Negative <= alu_res[WIDTH-1];
                Carry    <= alu_c;
                Overflow <= alu_v;
`ifdef ALU_EXEC_SHIFT_EN
                cnt      <= b_q[4:0];
`endif
            end
`ifdef ALU_EXEC_SHIFT_EN
            else if (state == SHIFT) begin
                Result   <= shl;
                Zero     <= (shl == '0);
                Negative <= shl[WIDTH-1];
                Carry    <= Result[WIDTH-1];
                Overflow <= 1'b0;
                cnt      <= cnt - 5'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table plus scoreboard, stall/back-to-back and reset-abort sequences.
// Build with ALU_EXEC_SHIFT_EN defined to exercise the sll path.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [35:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (alu_ctl),
        .SrcA       (src_a),
        .SrcB       (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (result),
        .Zero       (zero),
        .Negative   (negative),
        .Carry      (carry),
        .Overflow   (overflow),
        .busy       (busy)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // scoreboard: every output handshake pops one expected {Result, Z, N, C, V}
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got result 0x%0h required no output", result);
            end else begin
                chk("sb_result_flags", {28'd0, result, zero, negative, carry, overflow},
                    {28'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [35:0] model_addsub(input logic sub, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      s;
        logic [31:0] r;
        logic        c;
        logic        v;
        if (!sub) begin
            r = a + b;
            c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
            s = longint'($signed(a)) + longint'($signed(b));
        end else begin
            r = a - b;
            c = (a >= b);
            s = longint'($signed(a)) - longint'($signed(b));
        end
        v = (s != longint'($signed(r)));
        return {r, (r == 32'd0), r[31], c, v};
    endfunction

    // driver: issue from IDLE, measure accept-to-out_valid latency, let out_ready=1 drain it
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [35:0] exp, input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        alu_ctl  = op;
        src_a    = a;
        src_b    = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsub;
        int          lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctl   = 3'b000;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;

        // flags field is {Zero, Negative, Carry, Overflow}
        vecs.push_back('{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 2});
        vecs.push_back('{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010, 2});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 2});
        vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 2});
        vecs.push_back('{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1011, 2});
        vecs.push_back('{3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0100, 2});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 2});
        vecs.push_back('{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, 2});
        vecs.push_back('{3'b011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000, 2});
        vecs.push_back('{3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 2});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 2});
        vecs.push_back('{3'b110, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1000, 2});
        vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 2});
`ifdef ALU_EXEC_SHIFT_EN
        vecs.push_back('{3'b100, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0010, 3});
        vecs.push_back('{3'b100, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 4'b0000, 2});
        vecs.push_back('{3'b100, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 4'b0110, 33});
        vecs.push_back('{3'b100, 32'h0000_FFFF, 32'hFFFF_FFE4, 32'h000F_FFF0, 4'b0000, 6});
`else
        vecs.push_back('{3'b100, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 4'b1000, 2});
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result_flags", {28'd0, result, zero, negative, carry, overflow}, 64'd0);

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].res, vecs[i].flags}, vecs[i].lat);

        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = (i == 3) ? ra : $urandom;
            rsub = 1'($urandom_range(0, 1));
            do_op({2'b00, rsub}, ra, rb, model_addsub(rsub, ra, rb), 2);
        end

        // stall with out_ready low, then back-to-back accept on the draining handshake
        out_ready = 1'b0;
        exp_q.push_back({32'd5, 4'b0000});
        in_valid = 1'b1;
        alu_ctl  = 3'b000;
        src_a    = 32'd2;
        src_b    = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("stall_latency", 64'(lat), 64'd2);
        for (int k = 0; k < 4; k++) begin
            chk("stall_hold", {27'd0, out_valid, result, zero, negative, carry, overflow},
                {27'd1, 32'd5, 4'b0000});
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        exp_q.push_back({32'd3, 4'b0000});
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_ctl   = 3'b011;
        src_a     = 32'd1;
        src_b     = 32'd2;
        @(negedge clk);
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("b2b_no_bubble_exec", {62'd0, busy, out_valid}, 64'd2);
        while (!out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("b2b_latency", 64'(lat), 64'd2);
        @(posedge clk); #1;

        // reset pulsed while in EXEC aborts the operation
        in_valid = 1'b1;
        alu_ctl  = 3'b000;
        src_a    = 32'd1;
        src_b    = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_busy_exec", {62'd0, busy, out_valid}, 64'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result_flags", {28'd0, result, zero, negative, carry, overflow}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_output", {63'd0, out_valid}, 64'd0);

        do_op(3'b001, 32'h0000_0000, 32'h0000_0001, {32'hFFFF_FFFF, 4'b0100}, 2);

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
